rsp_reorder_buffer: RTL and testbench

RSP_REORDER_BUFFER -- requirements
Module: rsp_reorder_buffer

---
 rtl/rsp_reorder_buffer.sv | 139 +++++++++++++
 tb/tb_rsp_reorder_buffer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rsp_reorder_buffer.sv
// ---------------------------------------------------------------------------
// rsp_reorder_buffer
//
// Purpose:
//   Hands out read tags in order, accepts their responses in any order, and
//   releases the responses downstream strictly in the order the tags were
//   allocated. DEPTH = 2**TAG_WIDTH transactions may be in flight at once.
//
// Ports:
//   clk, rst         clock (rising edge) and synchronous active-high reset
//   alloc_req        upstream wants a tag for a new read
//   alloc_ok         a tag is free this cycle (alloc taken on req & ok)
//   alloc_tag        tag granted this cycle
//   rsp_valid        response channel has an entry
//   rsp_tag          tag of that response
//   rsp_data         payload of that response
//   rsp_rd_en        pop strobe back to the response channel
//   out_valid        in-order head response available
//   out_ready        downstream accepts the head response
//   out_tag          tag of the head response
//   out_data         payload of the head response
//   occupancy        allocated but not yet retired tags (0..DEPTH)
//   err              sticky: response for a non-pending or already-filled tag
// ---------------------------------------------------------------------------
module rsp_reorder_buffer #(
    parameter int TAG_WIDTH  = 3,
    parameter int DATA_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_req,
    output logic                  alloc_ok,
    output logic [TAG_WIDTH-1:0]  alloc_tag,
    input  logic                  rsp_valid,
    input  logic [TAG_WIDTH-1:0]  rsp_tag,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_rd_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH:0]    occupancy,
    output logic                  err
);

    localparam int                DEPTH   = 1 << TAG_WIDTH;
    localparam logic [TAG_WIDTH:0] DEPTH_P = (TAG_WIDTH + 1)'(DEPTH);

    // Pointers carry one extra wrap bit so full (diff == DEPTH) and empty
    // (diff == 0) are distinguishable.
    logic [TAG_WIDTH:0]    alloc_ptr_q,  alloc_ptr_d;
    logic [TAG_WIDTH:0]    retire_ptr_q, retire_ptr_d;
    logic [DEPTH-1:0]      pending_q,    pending_d;
    logic [DEPTH-1:0]      filled_q,     filled_d;
    logic                  err_q,        err_d;
    logic [DATA_WIDTH-1:0] store_q [DEPTH];

    logic [TAG_WIDTH:0]    occ_raw;
    logic [TAG_WIDTH-1:0]  alloc_idx;
    logic [TAG_WIDTH-1:0]  head_idx;
    logic                  alloc_fire;
    logic                  retire_fire;
    logic                  rsp_accept;
    logic                  rsp_reject;

    assign occ_raw   = alloc_ptr_q - retire_ptr_q;
    assign alloc_idx = alloc_ptr_q[TAG_WIDTH-1:0];
    assign head_idx  = retire_ptr_q[TAG_WIDTH-1:0];

    // Outputs are gated by rst so they read as idle while reset is held,
    // even before the first reset edge has cleared the state.
    assign alloc_ok  = ~rst & (occ_raw < DEPTH_P);
    assign alloc_tag = alloc_idx;
    assign rsp_rd_en = rsp_valid & ~rst;
    assign out_valid = filled_q[head_idx] & ~rst;
    assign out_tag   = head_idx;
    assign out_data  = store_q[head_idx];
    assign occupancy = rst ? '0 : occ_raw;
    assign err       = err_q & ~rst;

    assign alloc_fire  = alloc_req & alloc_ok;
    assign retire_fire = out_valid & out_ready;
    assign rsp_accept  = rsp_rd_en & pending_q[rsp_tag] & ~filled_q[rsp_tag];
    assign rsp_reject  = rsp_rd_en & ~(pending_q[rsp_tag] & ~filled_q[rsp_tag]);

    always_comb begin
        // NOTE: combinational blocks use blocking '=' and assign every output
        // a default first, so later lines can override it without a latch.
        alloc_ptr_d  = alloc_ptr_q + (TAG_WIDTH + 1)'(alloc_fire);
        retire_ptr_d = retire_ptr_q + (TAG_WIDTH + 1)'(retire_fire);
        pending_d    = pending_q;
        filled_d     = filled_q;
        err_d        = err_q | rsp_reject;

        if (retire_fire) begin
            pending_d[head_idx] = 1'b0;
            filled_d[head_idx]  = 1'b0;
        end

        // A filled head can never also be an accepted response target, so
        // this cannot collide with the retire clear above.
        if (rsp_accept) begin
            filled_d[rsp_tag] = 1'b1;
        end

        // Applied after the retire clear: an index reused in the same cycle
        // it retires ends up pending and not filled.
        if (alloc_fire) begin
            pending_d[alloc_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking '<=' so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            alloc_ptr_q  <= '0;
            retire_ptr_q <= '0;
            pending_q    <= '0;
            filled_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            alloc_ptr_q  <= alloc_ptr_d;
            retire_ptr_q <= retire_ptr_d;
            pending_q    <= pending_d;
            filled_q     <= filled_d;
            err_q        <= err_d;
        end
    end

    // NOTE: the payload store has no reset; the filled bits already say which
    // entries hold meaningful data, and leaving it unreset lets it map to RAM.
    always_ff @(posedge clk) begin
        if (rsp_accept) begin
            store_q[rsp_tag] <= rsp_data;
        end
    end

endmodule

// File: tb/tb_rsp_reorder_buffer.sv
module tb_rsp_reorder_buffer;

    localparam int TW    = 3;
    localparam int DW    = 512;
    localparam int DEPTH = 1 << TW;

    logic          clk;
    logic          rst;
    logic          alloc_req;
    logic          alloc_ok;
    logic [TW-1:0] alloc_tag;
    logic          rsp_valid;
    logic [TW-1:0] rsp_tag;
    logic [DW-1:0] rsp_data;
    logic          rsp_rd_en;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] out_tag;
    logic [DW-1:0] out_data;
    logic [TW:0]   occupancy;
    logic          err;

    rsp_reorder_buffer #(.TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .alloc_req (alloc_req),
        .alloc_ok  (alloc_ok),
        .alloc_tag (alloc_tag),
        .rsp_valid (rsp_valid),
        .rsp_tag   (rsp_tag),
        .rsp_data  (rsp_data),
        .rsp_rd_en (rsp_rd_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tag   (out_tag),
        .out_data  (out_data),
        .occupancy (occupancy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: the outstanding transactions in allocation order.
    // The head of the list is the only one allowed out; a transaction may
    // leave once its response has arrived.
    typedef struct {
        logic [TW-1:0] tag;
        bit            filled;
        logic [DW-1:0] data;
    } txn_t;

    txn_t m_q[$];
    int   m_next_tag = 0;
    bit   m_err      = 1'b0;
    int   m_retired  = 0;
    int   m_allocs   = 0;

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
    task automatic cycle(input bit a_req, input bit r_valid, input int r_tag,
                         input logic [DW-1:0] r_data, input bit o_ready, input bit r_st);
        bit exp_aok;
        bit exp_ov;
        bit found;
        rst       = r_st;
        alloc_req = a_req;
        rsp_valid = r_valid;
        rsp_tag   = TW'(r_tag);
        rsp_data  = r_data;
        out_ready = o_ready;
        @(negedge clk);

        exp_aok = !r_st && (m_q.size() < DEPTH);
        exp_ov  = !r_st && (m_q.size() > 0) && m_q[0].filled;

        check("alloc_ok",  DW'(alloc_ok),  DW'(exp_aok));
        check("rsp_rd_en", DW'(rsp_rd_en), DW'(r_valid && !r_st));
        check("out_valid", DW'(out_valid), DW'(exp_ov));
        check("occupancy", DW'(occupancy), r_st ? '0 : DW'(m_q.size()));
        check("err",       DW'(err),       DW'(m_err && !r_st));
        if (!r_st) check("alloc_tag", DW'(alloc_tag), DW'(m_next_tag));
        if (exp_ov) begin
            check("out_tag",  DW'(out_tag), DW'(m_q[0].tag));
            check("out_data", out_data,     m_q[0].data);
        end

        if (r_st) begin
            m_q.delete();
            m_next_tag = 0;
            m_err      = 1'b0;
        end else begin
            if (r_valid) begin
                found = 1'b0;
                foreach (m_q[i]) begin
                    if (m_q[i].tag == TW'(r_tag)) begin
                        found = 1'b1;
                        if (m_q[i].filled) m_err = 1'b1;
                        else begin
                            m_q[i].filled = 1'b1;
                            m_q[i].data   = r_data;
                        end
                    end
                end
                if (!found) m_err = 1'b1;
            end
            if (exp_ov && o_ready) begin
                void'(m_q.pop_front());
                m_retired++;
            end
            if (a_req && exp_aok) begin
                m_q.push_back('{tag: TW'(m_next_tag), filled: 1'b0, data: '0});
                m_next_tag = (m_next_tag + 1) % DEPTH;
                m_allocs++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit o_ready);
        cycle(1'b0, 1'b0, 0, '0, o_ready, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 0, '0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        int cand[$];
        int pick;
        rst = 1'b1; alloc_req = 1'b0; rsp_valid = 1'b0; rsp_tag = '0;
        rsp_data = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset and first cycle after reset.
        do_reset();
        idle(1'b0);

        // Reverse-order responses: nothing leaves until tag 0 arrives.
        for (int t = 0; t < DEPTH; t++) cycle(1'b1, 1'b0, 0, '0, 1'b1, 1'b0);
        for (int t = DEPTH - 1; t >= 0; t--)
            cycle(1'b0, 1'b1, t, DW'(16'h1111 * t), 1'b1, 1'b0);
        m_retired = 0;
        for (int c = 0; c < DEPTH + 2; c++) idle(1'b1);
        check("rev_retired", DW'(m_retired), DW'(DEPTH));

        // Full buffer: alloc blocked, a same-cycle retire does not unblock it.
        do_reset();
        for (int t = 0; t < DEPTH; t++) cycle(1'b1, 1'b0, 0, '0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 0, DW'(64'hdead_beef_0000_0001), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 0, '0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 0, '0, 1'b0, 1'b0);
        idle(1'b0);

        // Response to an unallocated tag after reset.
        do_reset();
        cycle(1'b0, 1'b1, 5, DW'(64'h5555), 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);

        // Head held under back-pressure, then retired.
        do_reset();
        cycle(1'b1, 1'b0, 0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 0, {8{64'hcafe_f00d_1234_5678}}, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // Duplicate response to an already-filled tag.
        cycle(1'b1, 1'b0, 0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1, DW'(64'h11), 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1, DW'(64'h22), 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Reset mid-operation with five tags outstanding, then a stale response.
        do_reset();
        for (int t = 0; t < 5; t++) cycle(1'b1, 1'b0, 0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1, DW'(64'h77), 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 0, '0, 1'b0, 1'b1);
        idle(1'b0);
        cycle(1'b0, 1'b1, 2, DW'(64'h88), 1'b0, 1'b0);
        idle(1'b0);

        // Random traffic: 20 transactions, random response order and ready.
        do_reset();
        m_retired = 0;
        m_allocs  = 0;
        for (int c = 0; c < 2000 && m_retired < 20; c++) begin
            bit a;
            bit rv;
            int rt;
            cand.delete();
            foreach (m_q[i]) if (!m_q[i].filled) cand.push_back(i);
            a  = (m_allocs < 20) && ($urandom_range(0, 3) != 0);
            rv = (cand.size() > 0) && ($urandom_range(0, 1) == 1);
            rt = 0;
            if (rv) begin
                pick = cand[$urandom_range(0, cand.size() - 1)];
                rt   = int'(m_q[pick].tag);
            end
            cycle(a, rv, rt, {$urandom, $urandom, $urandom, $urandom},
                  $urandom_range(0, 3) != 0, 1'b0);
        end
        check("rand_retired", DW'(m_retired), DW'(20));
        idle(1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
